rast_rect_filler: RTL

//  Rasterizer stage directly upstream of dvi_framebuffer_top_level; replaces fake_rasterizer.

---
 rtl/rast_rect_filler_pkg.sv | 27 ++
 rtl/rast_rect_filler_walker.sv | 52 +++++
 rtl/rast_rect_filler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rast_rect_filler_pkg.sv
// Shared widths, default screen geometry and FSM state encoding for the
// rectangle-filling rasterizer stage.
package rast_rect_filler_pkg;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int COLOR_W      = 3;

  // state    | meaning
  // ST_IDLE  | reserved encoding, never entered
  // ST_CLEAR | walking the whole screen with the background colour
  // ST_FETCH | waiting for a draw command or end-of-frame marker
  // ST_DRAW  | walking the latched rectangle
  // ST_DONE  | rast_done pulse
  // ST_SWAP  | next_frame_switch pulse
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4,
    ST_SWAP  = 3'd5
  } state_t;

endpackage

// File: rtl/rast_rect_filler_walker.sv
// Raster walker: loads a rectangle and steps x (inner) then y (outer) on each
// accepted pixel; flags the final pixel of the rectangle.
module rast_rect_filler_walker
  import rast_rect_filler_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [X_W-1:0]     xmin,
  input  logic [X_W-1:0]     xmax,
  input  logic [Y_W-1:0]     ymin,
  input  logic [Y_W-1:0]     ymax,
  input  logic [COLOR_W-1:0] color_in,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] color,
  output logic               last
);

  logic [X_W-1:0] xmin_q;
  logic [X_W-1:0] xmax_q;
  logic [Y_W-1:0] ymax_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      color  <= '0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
    end else if (load) begin
      x      <= xmin;
      y      <= ymin;
      color  <= color_in;
      xmin_q <= xmin;
      xmax_q <= xmax;
      ymax_q <= ymax;
    end else if (advance) begin
      if (x == xmax_q) begin
        x <= xmin_q;
        y <= y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

  assign last = (x == xmax_q) && (y == ymax_q);

endmodule

// File: rtl/rast_rect_filler.sv
// Filled-rectangle rasterizer feeding the framebuffer: optional background clear,
// clipped rectangle fills, then rast_done / next_frame_switch at end of frame.
module rast_rect_filler
  import rast_rect_filler_pkg::*;
#(
  parameter int                 SCREEN_W = DEF_SCREEN_W,
  parameter int                 SCREEN_H = DEF_SCREEN_H,
  parameter bit                 CLEAR_EN = 1'b1,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_eof,
  input  logic [X_W-1:0]     cmd_x0,
  input  logic [X_W-1:0]     cmd_x1,
  input  logic [Y_W-1:0]     cmd_y0,
  input  logic [Y_W-1:0]     cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               read_rast_pixel_rdy,
  output logic               rast_pixel_rdy,
  output logic [X_W-1:0]     rast_width,
  output logic [Y_W-1:0]     rast_height,
  output logic [COLOR_W-1:0] rast_color_input,
  output logic               rast_done,
  output logic               next_frame_switch,
  output logic               busy
);

  localparam logic [X_W-1:0] X_LAST   = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(SCREEN_H - 1);
  localparam state_t         START_ST = CLEAR_EN ? ST_CLEAR : ST_FETCH;

  state_t             state, state_next;
  logic               pix_vld, ready_q, busy_q, done_q, swap_q;
  logic               xfer, accept, last;
  logic               load;
  logic [X_W-1:0]     ld_xmin, ld_xmax;
  logic [Y_W-1:0]     ld_ymin, ld_ymax;
  logic [COLOR_W-1:0] ld_color;
  logic [X_W-1:0]     cx_lo, cx_hi, cx_max;
  logic [Y_W-1:0]     cy_lo, cy_hi, cy_max;
  logic               cmd_empty;

  assign xfer   = pix_vld && read_rast_pixel_rdy;
  assign accept = cmd_valid && ready_q && (state == ST_FETCH);

  // Corners may arrive in either order; clip only the upper bound, an
  // off-screen lower bound means nothing of the rectangle is visible.
  assign cx_lo     = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
  assign cx_max    = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
  assign cy_lo     = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
  assign cy_max    = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
  assign cx_hi     = (cx_max > X_LAST) ? X_LAST : cx_max;
  assign cy_hi     = (cy_max > Y_LAST) ? Y_LAST : cy_max;
  assign cmd_empty = (cx_lo > X_LAST) || (cy_lo > Y_LAST);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    ld_xmin    = '0;
    ld_xmax    = X_LAST;
    ld_ymin    = '0;
    ld_ymax    = Y_LAST;
    ld_color   = BG_COLOR;
    case (state)
      ST_CLEAR: begin
        if (!pix_vld) load = 1'b1;
        else if (xfer && last) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (accept) begin
          if (cmd_eof) begin
            state_next = ST_DONE;
          end else if (!cmd_empty) begin
            load       = 1'b1;
            ld_xmin    = cx_lo;
            ld_xmax    = cx_hi;
            ld_ymin    = cy_lo;
            ld_ymax    = cy_hi;
            ld_color   = cmd_color;
            state_next = ST_DRAW;
          end
        end
      end
      ST_DRAW:  if (xfer && last) state_next = ST_FETCH;
      ST_DONE:  state_next = ST_SWAP;
      ST_SWAP:  state_next = START_ST;
      default:  state_next = START_ST;
    endcase
  end

  // Status outputs are registered from the next state so that every output
  // reads 0 while reset is held, regardless of the start state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= START_ST;
      pix_vld <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == ST_FETCH);
      busy_q  <= (state_next != ST_FETCH);
      done_q  <= (state_next == ST_DONE);
      swap_q  <= (state_next == ST_SWAP);
      if (load) pix_vld <= 1'b1;
      else if (xfer && last) pix_vld <= 1'b0;
    end
  end

  rast_rect_filler_walker u_walker (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .advance  (xfer),
    .xmin     (ld_xmin),
    .xmax     (ld_xmax),
    .ymin     (ld_ymin),
    .ymax     (ld_ymax),
    .color_in (ld_color),
    .x        (rast_width),
    .y        (rast_height),
    .color    (rast_color_input),
    .last     (last)
  );

  assign rast_pixel_rdy    = pix_vld;
  assign cmd_ready         = ready_q;
  assign busy              = busy_q;
  assign rast_done         = done_q;
  assign next_frame_switch = swap_q;

endmodule
